// File: rtl/accel_req_arbiter.sv
// Round-robin arbiter sharing Ara's accelerator request/response port between NumReq sources.
// Optional performance counters are compiled in when ACCEL_ARB_PERF_EN is defined.
module accel_req_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned XLEN           = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      req_valid_i,
    output logic [NumReq-1:0]      req_ready_o,
    input  logic [NumReq*32-1:0]   req_insn_i,
    input  logic [NumReq*XLEN-1:0] req_rs1_i,
    input  logic [NumReq*XLEN-1:0] req_rs2_i,
    output logic [NumReq-1:0]      resp_valid_o,
    input  logic [NumReq-1:0]      resp_ready_i,
    output logic [XLEN-1:0]        resp_result_o,
    output logic                   resp_error_o,
    output logic                   acc_req_valid_o,
    input  logic                   acc_req_ready_i,
    output logic [31:0]            acc_insn_o,
    output logic [XLEN-1:0]        acc_rs1_o,
    output logic [XLEN-1:0]        acc_rs2_o,
    input  logic                   acc_resp_valid_i,
    output logic                   acc_resp_ready_o,
    input  logic [XLEN-1:0]        acc_result_i,
    input  logic                   acc_error_i
`ifdef ACCEL_ARB_PERF_EN
    ,
    output logic [NumReq*32-1:0]   perf_grant_cnt_o,
    output logic [31:0]            perf_stall_cnt_o
`endif
);

    localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } lock_state_e;

    lock_state_e     state, state_next;
    logic [IdW-1:0]  rr_ptr, locked_id, grant, head;
    logic [IdW-1:0]  ids [MaxOutstanding];
    logic [PtrW-1:0] rd, wr;
    logic [CntW-1:0] cnt;
    logic            full, empty, push, pop, stall;

    logic [31:0]     insn_arr [NumReq];
    logic [XLEN-1:0] rs1_arr  [NumReq];
    logic [XLEN-1:0] rs2_arr  [NumReq];

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            insn_arr[i] = req_insn_i[i*32 +: 32];
            rs1_arr[i]  = req_rs1_i[i*XLEN +: XLEN];
            rs2_arr[i]  = req_rs2_i[i*XLEN +: XLEN];
        end
    end

    // First valid source at or after rr_ptr; with nobody valid the grant rests on rr_ptr.
    always_comb begin
        logic        found;
        int unsigned idx;
        grant = rr_ptr;
        found = 1'b0;
        idx   = 0;
        if (state == ST_LOCKED) begin
            grant = locked_id;
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                idx = (32'(rr_ptr) + i) % NumReq;
                if (!found && req_valid_i[idx]) begin
                    grant = IdW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        acc_insn_o = insn_arr[grant];
        acc_rs1_o  = rs1_arr[grant];
        acc_rs2_o  = rs2_arr[grant];
    end

    // Response side is resolved first so a same-cycle pop can release a full FIFO.
    always_comb begin
        empty            = (cnt == '0);
        full             = (cnt == CntW'(MaxOutstanding));
        head             = ids[rd];
        resp_valid_o     = '0;
        acc_resp_ready_o = 1'b0;
        if (!rst_i && !empty) begin
            resp_valid_o[head] = acc_resp_valid_i;
            acc_resp_ready_o   = resp_ready_i[head];
        end
        pop   = acc_resp_valid_i & acc_resp_ready_o;
        stall = full & ~pop;

        acc_req_valid_o = 1'b0;
        req_ready_o     = '0;
        if (!rst_i && !stall) begin
            acc_req_valid_o    = req_valid_i[grant];
            req_ready_o[grant] = acc_req_ready_i;
        end
        push = acc_req_valid_o & acc_req_ready_i;

        resp_result_o = acc_result_i;
        resp_error_o  = acc_error_i;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FREE:   if (acc_req_valid_o && !acc_req_ready_i) state_next = ST_LOCKED;
            ST_LOCKED: if (push) state_next = ST_FREE;
            default:   state_next = ST_FREE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_FREE;
            rr_ptr    <= '0;
            locked_id <= '0;
            rd        <= '0;
            wr        <= '0;
            cnt       <= '0;
        end else begin
            state <= state_next;
            if (acc_req_valid_o && !acc_req_ready_i) locked_id <= grant;
            if (push) begin
                rr_ptr <= (grant == IdW'(NumReq - 1)) ? '0 : grant + 1'b1;
                wr     <= (wr == PtrW'(MaxOutstanding - 1)) ? '0 : wr + 1'b1;
            end
            if (pop) rd <= (rd == PtrW'(MaxOutstanding - 1)) ? '0 : rd + 1'b1;
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    // ID storage needs no reset: cnt alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) ids[wr] <= grant;
    end

`ifdef ACCEL_ARB_PERF_EN
    logic [31:0] grant_cnt [NumReq];
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumReq; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            if (push) grant_cnt[grant] <= grant_cnt[grant] + 32'd1;
            if (|req_valid_i && !push) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        perf_grant_cnt_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) perf_grant_cnt_o[i*32 +: 32] = grant_cnt[i];
    end

    assign perf_stall_cnt_o = stall_cnt;
`endif

`ifndef SYNTHESIS
    resp_without_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i) !(acc_resp_valid_i && empty)
    );
`endif

endmodule
